// File: rtl/tpm_fifo_channel.sv
// TIS DATA_FIFO byte buffer: captures one TPM command/response stream, parses the
// big-endian header size field, drives STS expect/dataAvail and supports replay.
module tpm_fifo_channel #(
    parameter int  DEPTH    = 2048,
    parameter int  MIN_SIZE = 10,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wrValid,
    input  logic [7:0]       wrData,
    input  logic             rdReq,
    input  logic             rewind,
    output logic [7:0]       rdData,
    output logic             rdValid,
    output logic [CNT_W-1:0] byteCount,
    output logic [31:0]      cmdSize,
    output logic             sizeKnown,
    output logic             stsExpect,
    output logic             stsDataAvail,
    output logic             cmdComplete,
    output logic             errOverflow
);

    localparam int               ADDR_W  = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_EMPTY    = 3'd0,
        ST_HEADER   = 3'd1,
        ST_BODY     = 3'd2,
        ST_COMPLETE = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [23:0]        acc_q, acc_d;
    logic [31:0]        size_q, size_d;
    logic               known_q, known_d;
    logic               expect_q, expect_d;
    logic               avail_q, avail_d;
    logic               cmpl_q, cmpl_d;
    logic               ovf_q, ovf_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_hit_q, rd_hit_d;
    logic [7:0]         rd_mem_q;
    logic [7:0]         mem [DEPTH];

    logic               wr_en_s;
    logic [CNT_W-1:0]   next_count_s;
    logic [CNT_W-1:0]   eff_rd_s;
    logic [ADDR_W-1:0]  rd_addr_s;
    logic [31:0]        assembled_s;

    assign next_count_s = count_q + CNT_ONE;
    assign assembled_s  = {acc_q, wrData};
    // Rewind takes effect before a same-cycle read, so the replay starts at byte 0.
    assign eff_rd_s     = rewind ? {CNT_W{1'b0}} : rd_ptr_q;
    assign rd_addr_s    = eff_rd_s[ADDR_W-1:0];

    // Next-state: stream FSM, header parse, read pointer and STS flags
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        acc_d      = acc_q;
        size_d     = size_q;
        known_d    = known_q;
        ovf_d      = ovf_q;
        cmpl_d     = 1'b0;
        rd_valid_d = 1'b0;
        rd_hit_d   = 1'b0;
        wr_en_s    = 1'b0;
        if (clear) begin
            state_d  = ST_EMPTY;
            count_d  = {CNT_W{1'b0}};
            rd_ptr_d = {CNT_W{1'b0}};
            acc_d    = 24'h00_0000;
            size_d   = 32'h0000_0000;
            known_d  = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (wrValid) begin
                        wr_en_s = 1'b1;
                        count_d = CNT_ONE;
                        state_d = ST_HEADER;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_HEADER: begin
                    if (wrValid) begin
                        wr_en_s = 1'b1;
                        count_d = next_count_s;
                        case (count_q)
                            CNT_W'(2): acc_d[23:16] = wrData;
                            CNT_W'(3): acc_d[15:8]  = wrData;
                            CNT_W'(4): acc_d[7:0]   = wrData;
                            CNT_W'(5): begin
                                size_d  = assembled_s;
                                known_d = 1'b1;
                                if ((assembled_s < 32'(MIN_SIZE)) || (assembled_s > 32'(DEPTH))) begin
                                    state_d = ST_ERROR;
                                    ovf_d   = 1'b1;
                                end else begin
                                    state_d = ST_BODY;
                                end
                            end
                            default: acc_d = acc_q;
                        endcase
                    end else begin
                        state_d = ST_HEADER;
                    end
                end
                ST_BODY: begin
                    if (wrValid) begin
                        wr_en_s = 1'b1;
                        count_d = next_count_s;
                        if (32'(next_count_s) == size_q) begin
                            state_d = ST_COMPLETE;
                            cmpl_d  = 1'b1;
                        end else begin
                            state_d = ST_BODY;
                        end
                    end else begin
                        state_d = ST_BODY;
                    end
                end
                ST_COMPLETE: begin
                    if (wrValid) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                end
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_EMPTY;
            endcase

            rd_ptr_d = eff_rd_s;
            if (rdReq) begin
                rd_valid_d = 1'b1;
                if ((state_q == ST_COMPLETE) && (eff_rd_s != count_q)) begin
                    rd_hit_d = 1'b1;
                    rd_ptr_d = eff_rd_s + CNT_ONE;
                end else begin
                    rd_hit_d = 1'b0;
                end
            end else begin
                rd_valid_d = 1'b0;
            end
        end
        expect_d = (state_d == ST_HEADER) || (state_d == ST_BODY);
        avail_d  = (state_d == ST_COMPLETE) && (rd_ptr_d != count_d);
    end

    // Control and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            count_q    <= {CNT_W{1'b0}};
            rd_ptr_q   <= {CNT_W{1'b0}};
            acc_q      <= 24'h00_0000;
            size_q     <= 32'h0000_0000;
            known_q    <= 1'b0;
            expect_q   <= 1'b0;
            avail_q    <= 1'b0;
            cmpl_q     <= 1'b0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            acc_q      <= acc_d;
            size_q     <= size_d;
            known_q    <= known_d;
            expect_q   <= expect_d;
            avail_q    <= avail_d;
            cmpl_q     <= cmpl_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_hit_q   <= rd_hit_d;
        end
    end

    // Byte store: one write port, one registered read port (no reset, BRAM-friendly)
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[count_q[ADDR_W-1:0]] <= wrData;
        end
        rd_mem_q <= mem[rd_addr_s];
    end

    assign rdData       = rd_valid_q ? (rd_hit_q ? rd_mem_q : 8'hFF) : 8'h00;
    assign rdValid      = rd_valid_q;
    assign byteCount    = count_q;
    assign cmdSize      = size_q;
    assign sizeKnown    = known_q;
    assign stsExpect    = expect_q;
    assign stsDataAvail = avail_q;
    assign cmdComplete  = cmpl_q;
    assign errOverflow  = ovf_q;

endmodule

// File: tb/tb_tpm_fifo_channel.sv
// Self-checking bench for tpm_fifo_channel: vector table for the reference stream,
// read scoreboard, and hand-written sequences for error, boundary and reset cases.
module tb_tpm_fifo_channel;

    localparam int DEPTH = 2048;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset, clear, wrValid, rdReq, rewind;
    logic [7:0]       wrData, rdData;
    logic             rdValid, sizeKnown, stsExpect, stsDataAvail, cmdComplete, errOverflow;
    logic [CNT_W-1:0] byteCount;
    logic [31:0]      cmdSize;

    tpm_fifo_channel dut (
        .clk(clk), .reset(reset), .clear(clear), .wrValid(wrValid), .wrData(wrData),
        .rdReq(rdReq), .rewind(rewind), .rdData(rdData), .rdValid(rdValid),
        .byteCount(byteCount), .cmdSize(cmdSize), .sizeKnown(sizeKnown),
        .stsExpect(stsExpect), .stsDataAvail(stsDataAvail), .cmdComplete(cmdComplete),
        .errOverflow(errOverflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             wr;
        logic [7:0]       d;
        logic [CNT_W-1:0] cnt;
        logic             sk;
        logic             ex;
        logic             av;
        logic             cc;
        logic             ov;
        logic [31:0]      sz;
    } vec_t;

    vec_t       tbl [12];
    logic [7:0] stream [12];
    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         mdl_rp   = 0;
    int         mdl_len  = 0;
    bit         mdl_complete = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock with the given inputs; the read model pushes expectations, which are popped a cycle later
    task automatic cycle(input logic wr, input logic [7:0] d, input logic rd,
                         input logic rew, input logic clr);
        wrValid = wr; wrData = d; rdReq = rd; rewind = rew; clear = clr;
        if (clr) begin
            mdl_rp = 0;
            mdl_complete = 1'b0;
        end else begin
            if (rew) mdl_rp = 0;
            if (rd) begin
                if (mdl_complete && (mdl_rp < mdl_len)) begin
                    exp_q.push_back(stream[mdl_rp]);
                    mdl_rp++;
                end else begin
                    exp_q.push_back(8'hFF);
                end
            end
        end
        @(posedge clk);
        #1;
        wrValid = 1'b0; wrData = 8'h00; rdReq = 1'b0; rewind = 1'b0; clear = 1'b0;
        chk("rdValid", {31'd0, rdValid}, {31'd0, exp_q.size() > 0});
        if (exp_q.size() > 0) chk("rdData", {24'd0, rdData}, {24'd0, exp_q.pop_front()});
    endtask

    task automatic write_hdr(input logic [31:0] size);
        cycle(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, size[31:24], 1'b0, 1'b0, 1'b0);
        cycle(1'b1, size[23:16], 1'b0, 1'b0, 1'b0);
        cycle(1'b1, size[15:8], 1'b0, 1'b0, 1'b0);
        cycle(1'b1, size[7:0], 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".byteCount"}, 32'(byteCount), 32'd0);
        chk({tag, ".cmdSize"}, cmdSize, 32'd0);
        chk({tag, ".sizeKnown"}, {31'd0, sizeKnown}, 32'd0);
        chk({tag, ".stsExpect"}, {31'd0, stsExpect}, 32'd0);
        chk({tag, ".stsDataAvail"}, {31'd0, stsDataAvail}, 32'd0);
        chk({tag, ".cmdComplete"}, {31'd0, cmdComplete}, 32'd0);
        chk({tag, ".errOverflow"}, {31'd0, errOverflow}, 32'd0);
        chk({tag, ".rdValid"}, {31'd0, rdValid}, 32'd0);
        chk({tag, ".rdData"}, {24'd0, rdData}, 32'd0);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].wr, tbl[i].d, 1'b0, 1'b0, 1'b0);
            chk($sformatf("%s[%0d].byteCount", tag, i), 32'(byteCount), 32'(tbl[i].cnt));
            chk($sformatf("%s[%0d].sizeKnown", tag, i), {31'd0, sizeKnown}, {31'd0, tbl[i].sk});
            chk($sformatf("%s[%0d].stsExpect", tag, i), {31'd0, stsExpect}, {31'd0, tbl[i].ex});
            chk($sformatf("%s[%0d].stsDataAvail", tag, i), {31'd0, stsDataAvail}, {31'd0, tbl[i].av});
            chk($sformatf("%s[%0d].cmdComplete", tag, i), {31'd0, cmdComplete}, {31'd0, tbl[i].cc});
            chk($sformatf("%s[%0d].errOverflow", tag, i), {31'd0, errOverflow}, {31'd0, tbl[i].ov});
            chk($sformatf("%s[%0d].cmdSize", tag, i), cmdSize, tbl[i].sz);
        end
        mdl_complete = 1'b1;
        mdl_len = 12;
        mdl_rp = 0;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            chk($sformatf("%s[%0d].stsDataAvail", tag, i), {31'd0, stsDataAvail}, {31'd0, i < 11});
        end
    endtask

    initial begin
        //               wr    data   cnt     sk    ex    av    cc    ov    size
        tbl[0]  = '{1'b1, 8'h80, 12'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[1]  = '{1'b1, 8'h01, 12'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[2]  = '{1'b1, 8'h00, 12'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[3]  = '{1'b1, 8'h00, 12'd4,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[4]  = '{1'b1, 8'h00, 12'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[5]  = '{1'b1, 8'h0c, 12'd6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd12};
        tbl[6]  = '{1'b1, 8'h00, 12'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd12};
        tbl[7]  = '{1'b1, 8'h00, 12'd8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd12};
        tbl[8]  = '{1'b1, 8'h01, 12'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd12};
        tbl[9]  = '{1'b1, 8'h7b, 12'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd12};
        tbl[10] = '{1'b1, 8'h00, 12'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd12};
        tbl[11] = '{1'b1, 8'h00, 12'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd12};
        for (int i = 0; i < 12; i++) stream[i] = tbl[i].d;

        reset = 1'b1; clear = 1'b0; wrValid = 1'b0; wrData = 8'h00; rdReq = 1'b0; rewind = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 1'b0;

        // Reference stream, then full read-back
        run_table("stream");
        read_all("read");
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("read13.stsDataAvail", {31'd0, stsDataAvail}, 32'd0);

        // Replay, then rewind together with a read returns byte 0
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("rewind.stsDataAvail", {31'd0, stsDataAvail}, 32'd1);
        read_all("replay");
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("rew_rd.stsDataAvail", {31'd0, stsDataAvail}, 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_idle("clear1");
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Undersized field -> sticky error, writes dropped
        write_hdr(32'd8);
        chk("small.errOverflow", {31'd0, errOverflow}, 32'd1);
        chk("small.sizeKnown", {31'd0, sizeKnown}, 32'd1);
        chk("small.cmdSize", cmdSize, 32'd8);
        chk("small.stsExpect", {31'd0, stsExpect}, 32'd0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        chk("small.byteCount", 32'(byteCount), 32'd6);
        chk("small.stsDataAvail", {31'd0, stsDataAvail}, 32'd0);
        chk("small.errSticky", {31'd0, errOverflow}, 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_idle("clear2");

        // Size exactly MIN_SIZE is legal
        write_hdr(32'd10);
        chk("min.errOverflow", {31'd0, errOverflow}, 32'd0);
        chk("min.stsExpect", {31'd0, stsExpect}, 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // DEPTH+1 rejected
        write_hdr(32'(DEPTH + 1));
        chk("big.errOverflow", {31'd0, errOverflow}, 32'd1);
        chk("big.stsExpect", {31'd0, stsExpect}, 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Exactly DEPTH accepted and completes
        write_hdr(32'(DEPTH));
        chk("full.errOverflow", {31'd0, errOverflow}, 32'd0);
        for (int i = 6; i < DEPTH - 1; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("full.preCount", 32'(byteCount), 32'(DEPTH - 1));
        chk("full.preExpect", {31'd0, stsExpect}, 32'd1);
        chk("full.preComplete", {31'd0, cmdComplete}, 32'd0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        chk("full.cmdComplete", {31'd0, cmdComplete}, 32'd1);
        chk("full.byteCount", 32'(byteCount), 32'(DEPTH));
        chk("full.stsExpect", {31'd0, stsExpect}, 32'd0);
        chk("full.stsDataAvail", {31'd0, stsDataAvail}, 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("full.pulseEnd", {31'd0, cmdComplete}, 32'd0);
        cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        chk("full.extraOvf", {31'd0, errOverflow}, 32'd1);
        chk("full.extraCount", 32'(byteCount), 32'(DEPTH));
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_idle("clear3");

        // Asynchronous reset mid-stream
        for (int i = 0; i < 7; i++) cycle(1'b1, stream[i], 1'b0, 1'b0, 1'b0);
        chk("mid.byteCount", 32'(byteCount), 32'd7);
        reset = 1'b1;
        #1;
        check_idle("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Clear with a simultaneous write discards the write
        for (int i = 0; i < 3; i++) cycle(1'b1, stream[i], 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h80, 1'b0, 1'b0, 1'b1);
        check_idle("clear_wr");

        run_table("again");
        read_all("again_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
